gb_ppu_bg_pixel_fifo: RTL

Background/window pixel FIFO for the PPU's DRAW_PIXEL (mode 3) datapath: the consuming end of the pixel fetcher's PUSH state. Accepts rows of 8 `fifo_pixel_t` from the fetcher and shifts one pixel per cycle toward the LCD. Applies SCX fine-scroll discard at line start and maps colour IDs through BGP. Counts the 160 visible pixels of a line and flags line completion to the mode state machine.

---
 rtl/gb_ppu_bg_pixel_fifo.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/gb_ppu_bg_pixel_fifo.sv
// gb_ppu_bg_pixel_fifo
// Background/window pixel FIFO for the PPU DRAW_PIXEL (mode 3) datapath.
// Accepts 8-pixel rows from the pixel fetcher and shifts one pixel per dot
// toward the LCD. It also does three other jobs:
//   - drops the SCX fine-scroll pixels at the start of a line;
//   - maps colour IDs through BGP;
//   - counts the visible pixels and flags the end of the line.
//
// Each pixel nibble is a fifo_pixel_t laid out as
// {color[1:0], obj_palette, bg_priority}. Only the colour is used here.
//
// Ports:
//   clk           PPU dot clock
//   reset         asynchronous, active-high
//   line_start    single-cycle pulse at entry to DRAW_PIXEL (restarts the line)
//   scx_fine      SCX[2:0], sampled on line_start
//   push_valid    fetcher presents a row
//   push_data     8 pixels, [31:28] leftmost, [3:0] rightmost
//   push_ready    FIFO accepts the row this cycle
//   stall         freezes pops (object fetch); pushes still accepted
//   bgp           BG palette {id_3, id_2, id_1, id_0}, read at pop time
//   bg_win_enable LCDC bit 0; when low every shade is WHITE
//   pix_valid     registered: pix_color / pix_x valid this cycle
//   pix_color     registered shade
//   pix_x         registered LCD x coordinate
//   line_done     one-cycle pulse together with the pix_valid of the last pixel
//   fifo_count    current occupancy 0..16

module gb_ppu_bg_pixel_fifo #(
   parameter int DEPTH  = 16,
   parameter int LINE_W = 160
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        line_start,
   input  logic [2:0]  scx_fine,
   input  logic        push_valid,
   input  logic [31:0] push_data,
   output logic        push_ready,
   input  logic        stall,
   input  logic [7:0]  bgp,
   input  logic        bg_win_enable,
   output logic        pix_valid,
   output logic [1:0]  pix_color,
   output logic [7:0]  pix_x,
   output logic        line_done,
   output logic [4:0]  fifo_count
);

   typedef enum logic [1:0] {
      WHITE      = 2'd0,
      LIGHT_GREY = 2'd1,
      DARK_GREY  = 2'd2,
      BLACK      = 2'd3
   } pixel_color_t;

   logic       active;
   logic [4:0] count;
   logic [2:0] discard;
   logic [7:0] lx;
   logic [3:0] slots      [DEPTH];
   logic [3:0] slots_next [DEPTH];

   logic         push_fire;
   logic         pop_fire;
   logic         emit;
   logic [1:0]   head_color;
   pixel_color_t shade;
   logic [4:0]   base;
   logic         unused_head_attr;

   assign push_ready = active && (count <= 5'd8);
   assign fifo_count = count;
   assign push_fire  = push_valid && push_ready;
   assign pop_fire   = active && (count != 5'd0) && !stall;
   assign emit       = pop_fire && (discard == 3'd0);
   assign head_color = slots[0][3:2];

   // The object attribute bits of the head are never consulted by the BG path.
   assign unused_head_attr = ^slots[0][1:0];

   // Palette lookup for the head pixel. BGP packs id_n at bits [2n+1:2n].
   always_comb begin
      shade = pixel_color_t'(bgp[{head_color, 1'b0} +: 2]);
      if (!bg_win_enable) begin
         shade = WHITE;
      end
   end

   // Next slot contents. A pop shifts every entry one place toward the head.
   // A push writes the new row directly behind whatever survives the pop, so
   // a simultaneous push and pop lands the row at (count - 1).
   // push_ready limits count to 8, so base + 7 always fits inside 16 slots.
   always_comb begin
      slots_next = slots;
      if (pop_fire) begin
         for (int i = 0; i < DEPTH - 1; i++) begin
            slots_next[i] = slots[i + 1];
         end
         slots_next[DEPTH - 1] = 4'd0;
      end
      base = count - {4'd0, pop_fire};
      if (push_fire) begin
         for (int k = 0; k < 8; k++) begin
            slots_next[base[3:0] + 4'(k)] = push_data[(7 - k) * 4 +: 4];
         end
      end
   end

   // Line control, occupancy and the registered pixel output.
   // line_start takes priority over any push or pop in the same cycle.
   // Once the last visible pixel is emitted, the FIFO goes idle and keeps
   // its residual count until the next line_start.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         active    <= 1'b0;
         count     <= 5'd0;
         discard   <= 3'd0;
         lx        <= 8'd0;
         pix_valid <= 1'b0;
         pix_color <= WHITE;
         pix_x     <= 8'd0;
         line_done <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            slots[i] <= 4'd0;
         end
      end else begin
         pix_valid <= 1'b0;
         line_done <= 1'b0;
         if (line_start) begin
            active  <= 1'b1;
            count   <= 5'd0;
            discard <= scx_fine;
            lx      <= 8'd0;
         end else if (active) begin
            slots <= slots_next;
            count <= count + (push_fire ? 5'd8 : 5'd0) - {4'd0, pop_fire};
            if (pop_fire && (discard != 3'd0)) begin
               discard <= discard - 3'd1;
            end
            if (emit) begin
               pix_valid <= 1'b1;
               pix_color <= shade;
               pix_x     <= lx;
               lx        <= lx + 8'd1;
               if (lx == 8'(LINE_W - 1)) begin
                  line_done <= 1'b1;
                  active    <= 1'b0;
               end
            end
         end
      end
   end

endmodule
